tx_command_sequencer: RTL and testbench
=======================================

TX_COMMAND_SEQUENCER -- requirements
Module: tx_command_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 10'd1000, range 1..1023: WAIT_ACTIVE cycles allowed before start timeout.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  TX control register holds a pending command.
REQ-005 SHALL have port cmd  input  3  command code: 1 DATA, 2 ACK, 3 NAK, 4 STALL; 0 and 5-7 invalid.
REQ-006 SHALL have port buffer_occupancy  input  7  data buffer byte count.
REQ-007 SHALL have port tx_transfer_active  input  1  USB transmitter busy.
REQ-008 SHALL have port tx_error  input  1  USB transmitter error strobe.
REQ-009 SHALL have port tx_packet  output  2  packet type: 0 DATA, 1 ACK, 2 NAK, 3 STALL; valid while tx_start=1.
REQ-010 SHALL have port tx_start  output  1  one-cycle transmit request.
REQ-011 SHALL have port cmd_clear  output  1  one-cycle pulse clearing the TX control register.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port err  output  1  sticky status of the last command.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_IDLE, START, WAIT_ACTIVE, ACTIVE, DONE; all outputs registered or decoded from state only (Moore).
REQ-016 IDLE, cmd_valid=1, cmd in 1..4, not DATA-with-buffer_occupancy=0: latch cmd, clear err, go START if tx_transfer_active=0 else WAIT_IDLE.
REQ-017 IDLE, cmd_valid=1, cmd invalid or (cmd=1 and buffer_occupancy=7'd0): reject -- set err, go DONE, no tx_start.
REQ-018 cmd_clear SHALL be 1 for exactly the one cycle following an accept or reject edge, and 0 otherwise.
REQ-019 WAIT_IDLE: hold until tx_transfer_active=0, then go START.
REQ-020 START: tx_start=1 and tx_packet=latched cmd-1 for exactly one cycle; load timer 0; go WAIT_ACTIVE.
REQ-021 WAIT_ACTIVE: tx_transfer_active=1 -> ACTIVE; else timer increments; timer reaching TIMEOUT_CYCLES-1 with no active -> set err, go DONE.
REQ-022 ACTIVE: tx_transfer_active=0 -> DONE; tx_error=1 in WAIT_ACTIVE or ACTIVE SHALL set err (sticky).
REQ-023 tx_error coincident with tx_transfer_active falling SHALL both set err and go DONE in the same edge.
REQ-024 DONE: done=1 for one cycle; go IDLE unconditionally.
REQ-025 cmd_valid while busy=1 SHALL be ignored: no latch, no cmd_clear.
REQ-026 tx_packet SHALL be 2'd0 whenever tx_start=0.
REQ-027 Minimum accept-to-tx_start latency SHALL be 1 cycle (accept edge k, tx_start high in cycle k+1).
REQ-028 timer SHALL be 10 bits, saturating, never wrapping.

Reset
REQ-029 n_rst=0 SHALL asynchronously force state IDLE, timer 0, latched cmd 0, tx_start=0, tx_packet=0, cmd_clear=0, busy=0, done=0, err=0.
REQ-030 Reset mid-operation SHALL abandon the command with no done and no cmd_clear pulse after release.
REQ-031 First command SHALL be accepted on the first rising edge after n_rst deasserts.

Verification
REQ-032 ACK, tx idle: cmd=2, cmd_valid=1 -> next cycle tx_start=1, tx_packet=1, cmd_clear=1; active 5 cycles then low -> done=1 one cycle, err=0.
REQ-033 DATA, buffer_occupancy=0 -> cmd_clear=1, done=1, err=1, tx_start never asserted.
REQ-034 cmd=4 with tx_transfer_active=1 for 3 cycles -> WAIT_IDLE, tx_start 1 cycle after active drops, tx_packet=3.
REQ-035 TIMEOUT_CYCLES=4, tx_transfer_active held 0 after tx_start -> done and err=1 on the 5th cycle after tx_start.
REQ-036 NAK with tx_error pulse during ACTIVE, second cmd_valid while busy -> err=1 at done, second command ignored, no extra cmd_clear.
REQ-037 n_rst pulse during ACTIVE -> all outputs 0 immediately; next command after release starts cleanly with err=0.

Source files
------------

// File: rtl/tx_command_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tx_command_sequencer
// Description : Takes one pending command from the TX control register,
//               validates it, waits for the USB transmitter to be idle,
//               issues a one-cycle transmit request, then tracks the
//               transfer through to completion. Reports a sticky error
//               for rejected commands, start timeouts and transmitter errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_command_sequencer #(
    parameter logic [9:0] TIMEOUT_CYCLES = 10'd1000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       cmd_valid,
    input  logic [2:0] cmd,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    output logic [1:0] tx_packet,
    output logic       tx_start,
    output logic       cmd_clear,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_IDLE        = 3'd0;
    localparam logic [2:0] c_WAIT_IDLE   = 3'd1;
    localparam logic [2:0] c_START       = 3'd2;
    localparam logic [2:0] c_WAIT_ACTIVE = 3'd3;
    localparam logic [2:0] c_ACTIVE      = 3'd4;
    localparam logic [2:0] c_DONE        = 3'd5;

    // Command codes as seen in the TX control register
    localparam logic [2:0] c_CMD_DATA  = 3'd1;
    localparam logic [2:0] c_CMD_ACK   = 3'd2;
    localparam logic [2:0] c_CMD_NAK   = 3'd3;
    localparam logic [2:0] c_CMD_STALL = 3'd4;

    // Timer bounds: the timeout fires on the last permitted waiting cycle
    localparam logic [9:0] c_TIMER_MAX    = 10'h3FF;
    localparam logic [9:0] c_TIMEOUT_LAST = TIMEOUT_CYCLES - 10'd1;

    // ------------------------------------------------------------------------
    // Registers and decode wires
    // ------------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [9:0] r_timer;
    logic [2:0] r_cmd;
    logic       r_err;
    logic       r_cmd_clear;

    logic       w_cmd_legal;
    logic       w_idle_req;
    logic       w_accept;
    logic       w_reject;
    logic       w_timeout;
    logic       w_tx_fault;
    logic [1:0] w_pkt_code;

    // A DATA command with nothing buffered cannot be sent, so it is rejected
    // alongside the out-of-range codes.
    assign w_cmd_legal = (cmd >= c_CMD_DATA) && (cmd <= c_CMD_STALL) &&
                         !((cmd == c_CMD_DATA) && (buffer_occupancy == 7'd0));

    // Only IDLE looks at the register; requests while busy are ignored.
    assign w_idle_req = (r_state == c_IDLE) && cmd_valid;
    assign w_accept   = w_idle_req && w_cmd_legal;
    assign w_reject   = w_idle_req && !w_cmd_legal;

    // Transmitter never went active within the allowed window.
    assign w_timeout  = (r_state == c_WAIT_ACTIVE) && !tx_transfer_active &&
                        (r_timer == c_TIMEOUT_LAST);

    // Transmitter errors only count once our packet has been requested.
    assign w_tx_fault = tx_error &&
                        ((r_state == c_WAIT_ACTIVE) || (r_state == c_ACTIVE));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = tx_transfer_active ? c_WAIT_IDLE : c_START;
                end else if (w_reject) begin
                    w_next_state = c_DONE;
                end
            end
            c_WAIT_IDLE: begin
                if (!tx_transfer_active) begin
                    w_next_state = c_START;
                end
            end
            c_START: begin
                w_next_state = c_WAIT_ACTIVE;
            end
            c_WAIT_ACTIVE: begin
                if (tx_transfer_active) begin
                    w_next_state = c_ACTIVE;
                end else if (w_timeout) begin
                    w_next_state = c_DONE;
                end
            end
            c_ACTIVE: begin
                // An error on the falling edge of active still ends here;
                // the error flag is picked up by the status register.
                if (!tx_transfer_active) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Start-timeout timer: cleared in START, counts while waiting, saturates
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_timer <= 10'd0;
        end else if (r_state == c_START) begin
            r_timer <= 10'd0;
        end else if ((r_state == c_WAIT_ACTIVE) && !tx_transfer_active &&
                     (r_timer != c_TIMER_MAX)) begin
            r_timer <= r_timer + 10'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Latched command, captured on accept only
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cmd <= 3'd0;
        end else if (w_accept) begin
            r_cmd <= cmd;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error status: cleared by a new accepted command
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_reject || w_timeout || w_tx_fault) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Register-clear pulse for the cycle after any accept or reject
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cmd_clear <= 1'b0;
        end else begin
            r_cmd_clear <= w_idle_req;
        end
    end

    // ------------------------------------------------------------------------
    // Map latched command code to the transmitter packet type
    // ------------------------------------------------------------------------
    always_comb begin
        w_pkt_code = 2'd0;
        case (r_cmd)
            c_CMD_DATA:  w_pkt_code = 2'd0;
            c_CMD_ACK:   w_pkt_code = 2'd1;
            c_CMD_NAK:   w_pkt_code = 2'd2;
            c_CMD_STALL: w_pkt_code = 2'd3;
            default:     w_pkt_code = 2'd0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Moore output decode from state and latched command
    // ------------------------------------------------------------------------
    always_comb begin
        tx_start  = (r_state == c_START);
        tx_packet = (r_state == c_START) ? w_pkt_code : 2'd0;
        busy      = (r_state != c_IDLE);
        done      = (r_state == c_DONE);
        cmd_clear = r_cmd_clear;
        err       = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_command_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_command_sequencer
// Description : Directed vector table plus reset corner-case sequences for
//               tx_command_sequencer (TIMEOUT_CYCLES = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_command_sequencer;

    logic       clk;
    logic       n_rst;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [6:0] buffer_occupancy;
    logic       tx_transfer_active;
    logic       tx_error;
    logic [1:0] tx_packet;
    logic       tx_start;
    logic       cmd_clear;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks;
    int n_errors;

    typedef struct {
        logic       v;
        logic [2:0] cmd;
        logic [6:0] occ;
        logic       act;
        logic       terr;
        logic       ts;
        logic [1:0] pkt;
        logic       cc;
        logic       bsy;
        logic       dn;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    tx_command_sequencer #(
        .TIMEOUT_CYCLES(10'd4)
    ) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .cmd_valid         (cmd_valid),
        .cmd               (cmd),
        .buffer_occupancy  (buffer_occupancy),
        .tx_transfer_active(tx_transfer_active),
        .tx_error          (tx_error),
        .tx_packet         (tx_packet),
        .tx_start          (tx_start),
        .cmd_clear         (cmd_clear),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ts, input logic [1:0] pkt,
                           input logic cc, input logic bsy, input logic dn,
                           input logic er);
        chk({tag, ".tx_start"},  int'(tx_start),  int'(ts));
        chk({tag, ".tx_packet"}, int'(tx_packet), int'(pkt));
        chk({tag, ".cmd_clear"}, int'(cmd_clear), int'(cc));
        chk({tag, ".busy"},      int'(busy),      int'(bsy));
        chk({tag, ".done"},      int'(done),      int'(dn));
        chk({tag, ".err"},       int'(err),       int'(er));
    endtask

    // Inputs consumed at one edge, outputs expected just after that edge
    task automatic add(input logic v, input logic [2:0] c, input logic [6:0] o,
                       input logic a, input logic te, input logic ts,
                       input logic [1:0] pk, input logic cc, input logic bs,
                       input logic dn, input logic er);
        vec_t r;
        r.v = v; r.cmd = c; r.occ = o; r.act = a; r.terr = te;
        r.ts = ts; r.pkt = pk; r.cc = cc; r.bsy = bs; r.dn = dn; r.er = er;
        vecs.push_back(r);
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [6:0] o,
                         input logic a, input logic te);
        cmd_valid = v; cmd = c; buffer_occupancy = o;
        tx_transfer_active = a; tx_error = te;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        //   v cmd  occ  act te | ts pkt cc bsy dn er
        // ACK, transmitter idle, active for 5 cycles
        add(1, 3'd2, 7'd0, 0, 0,  1, 2'd1, 1, 1, 0, 0);
        add(0, 3'd0, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 1, 1, 0);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 0, 0, 0);
        // DATA with empty buffer: rejected
        add(1, 3'd1, 7'd0, 0, 0,  0, 2'd0, 1, 1, 1, 1);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 0, 0, 1);
        // Invalid code 6: rejected
        add(1, 3'd6, 7'd5, 0, 0,  0, 2'd0, 1, 1, 1, 1);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 0, 0, 1);
        // STALL while transmitter busy for 3 cycles
        add(1, 3'd4, 7'd0, 1, 0,  0, 2'd0, 1, 1, 0, 0);
        add(0, 3'd0, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 0, 0,  1, 2'd3, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 1, 1, 0);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 0, 0, 0);
        // DATA, error coincident with active falling
        add(1, 3'd1, 7'd5, 0, 0,  1, 2'd0, 1, 1, 0, 0);
        add(0, 3'd0, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 0, 1,  0, 2'd0, 0, 1, 1, 1);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 0, 0, 1);
        // NAK, error pulse in ACTIVE, requests while busy ignored
        add(1, 3'd3, 7'd0, 0, 0,  1, 2'd2, 1, 1, 0, 0);
        add(0, 3'd0, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 1, 1,  0, 2'd0, 0, 1, 0, 1);
        add(1, 3'd2, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 1);
        add(1, 3'd2, 7'd0, 0, 0,  0, 2'd0, 0, 1, 1, 1);
        add(1, 3'd2, 7'd0, 0, 0,  0, 2'd0, 0, 0, 0, 1);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 0, 0, 1);
        // ACK with no transmitter response: timeout on 5th cycle after start
        add(1, 3'd2, 7'd0, 0, 0,  1, 2'd1, 1, 1, 0, 0);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 1, 1, 1);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 0, 0, 1);
        // NAK, error while waiting for active: flag set, wait continues
        add(1, 3'd3, 7'd0, 0, 0,  1, 2'd2, 1, 1, 0, 0);
        add(0, 3'd0, 7'd0, 0, 1,  0, 2'd0, 0, 1, 0, 0);
        add(0, 3'd0, 7'd0, 0, 1,  0, 2'd0, 0, 1, 0, 1);
        add(0, 3'd0, 7'd0, 1, 0,  0, 2'd0, 0, 1, 0, 1);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 1, 1, 1);
        add(0, 3'd0, 7'd0, 0, 0,  0, 2'd0, 0, 0, 0, 1);

        // Reset state
        n_rst = 1'b0;
        drive(0, 3'd0, 7'd0, 0, 0);
        repeat (2) @(negedge clk);
        chk_all("reset", 0, 2'd0, 0, 0, 0, 0);
        n_rst = 1'b1;

        // Vector table; first row lands on the first edge after release
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].cmd, vecs[i].occ, vecs[i].act, vecs[i].terr);
            @(posedge clk);
            #1;
            chk_all($sformatf("row%0d", i), vecs[i].ts, vecs[i].pkt, vecs[i].cc,
                    vecs[i].bsy, vecs[i].dn, vecs[i].er);
            @(negedge clk);
        end

        // Reset pulse while ACTIVE with err already set
        drive(1, 3'd3, 7'd0, 0, 0);
        @(posedge clk); #1;
        chk("rst_seq.start", int'(tx_start), 1);
        @(negedge clk);
        drive(0, 3'd0, 7'd0, 1, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 3'd0, 7'd0, 1, 1);
        @(posedge clk); #1;
        chk("rst_seq.active_busy", int'(busy), 1);
        chk("rst_seq.active_err", int'(err), 1);
        @(negedge clk);
        tx_error = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        chk_all("rst_async", 0, 2'd0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 3'd0, 7'd0, 0, 0);
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_all($sformatf("post_rst%0d", i), 0, 2'd0, 0, 0, 0, 0);
            @(negedge clk);
        end
        drive(1, 3'd2, 7'd0, 0, 0);
        @(posedge clk); #1;
        chk_all("post_rst_cmd", 1, 2'd1, 1, 1, 0, 0);
        @(negedge clk);

        // Brief reset in IDLE; command waiting at release is taken on the first edge
        drive(0, 3'd0, 7'd0, 0, 0);
        n_rst = 1'b0;
        @(negedge clk);
        chk("idle_rst.busy", int'(busy), 0);
        drive(1, 3'd4, 7'd0, 0, 0);
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk_all("first_edge", 1, 2'd3, 1, 1, 0, 0);
        @(negedge clk);
        drive(0, 3'd0, 7'd0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
